// File: rtl/disp_pkg.sv
// Shared widths and digit-extraction helper for the display scan controller.
package disp_pkg;
   localparam int SEL_W      = 3;
   localparam int NIB_W      = 4;
   localparam int MAX_DIGITS = 8;

   function automatic logic [NIB_W-1:0] get_digit(input logic [NIB_W*MAX_DIGITS-1:0] v,
                                                  input logic [SEL_W-1:0]            i);
      return v[NIB_W*i +: NIB_W];
   endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// Purpose: digit-slot prescaler, one tick every CLK_DIV enabled cycles.
// Latency: tick is combinational from the counter register and en.
// Backpressure: none; en=0 parks the counter at zero.
module scan_tick_gen #(
   parameter int CLK_DIV = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);
   localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

   logic [PW-1:0] presc;

   assign tick = en & (presc == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (!en || tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end
endmodule

// File: rtl/display_scan_ctrl.sv
// Purpose: 8-digit multiplexed display scanner with per-frame snapshot and blanking guard.
// Latency: sel/nibble/blank are registered together from next-state values (1 cycle).
// Backpressure: none; en=0 holds sel, blanks, and makes the snapshot transparent.
// Optional: DISPLAY_SCAN_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module display_scan_ctrl
   import disp_pkg::*;
#(
   parameter int CLK_DIV    = 1000,
   parameter int BLANK_CYC  = 2,
   parameter int NUM_DIGITS = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic [NIB_W*MAX_DIGITS-1:0] digit_data,
   input  logic [MAX_DIGITS-1:0]       blank_mask,
   output logic [SEL_W-1:0]            sel,
   output logic [NIB_W-1:0]            nibble,
   output logic                        blank,
   output logic                        frame_done
);
   localparam int GW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

   logic                        tick;
   logic                        wrap;
   logic                        lz_nx;
   logic [SEL_W-1:0]            sel_nx;
   logic [GW-1:0]               guard;
   logic [GW-1:0]               guard_nx;
   logic [NIB_W*MAX_DIGITS-1:0] snap_data;
   logic [NIB_W*MAX_DIGITS-1:0] snap_data_nx;
   logic [MAX_DIGITS-1:0]       snap_mask;
   logic [MAX_DIGITS-1:0]       snap_mask_nx;

   scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .tick  (tick)
   );

   always_comb begin
      wrap   = tick && (sel == LAST_SEL);
      sel_nx = sel;
      if (tick) begin
         sel_nx = (sel == LAST_SEL) ? '0 : sel + 1'b1;
      end

      guard_nx = '0;
      if (en) begin
         if (tick) begin
            guard_nx = GW'(BLANK_CYC);
         end else if (guard != '0) begin
            guard_nx = guard - 1'b1;
         end
      end

      // Snapshot follows the inputs while idle so the first enabled frame shows live data.
      snap_data_nx = snap_data;
      snap_mask_nx = snap_mask;
      if (!en || wrap) begin
         snap_data_nx = digit_data;
         snap_mask_nx = blank_mask;
      end
   end

`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
   always_comb begin
      lz_nx = (sel_nx != '0);
      for (int k = 0; k < MAX_DIGITS; k++) begin
         if (k < NUM_DIGITS && k >= int'(sel_nx) &&
             get_digit(snap_data_nx, SEL_W'(k)) != '0) begin
            lz_nx = 1'b0;
         end
      end
   end
`else
   assign lz_nx = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel        <= '0;
         guard      <= '0;
         snap_data  <= '0;
         snap_mask  <= '0;
         nibble     <= '0;
         blank      <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         sel        <= sel_nx;
         guard      <= guard_nx;
         snap_data  <= snap_data_nx;
         snap_mask  <= snap_mask_nx;
         nibble     <= get_digit(snap_data_nx, sel_nx);
         blank      <= ~en | (guard_nx != '0) | snap_mask_nx[sel_nx] | lz_nx;
         frame_done <= wrap;
      end
   end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl: three configurations against a slot/frame reference model.
module tb_display_scan_ctrl;
   localparam int N = 3;
   localparam int P_CD [N] = '{4, 4, 2};
   localparam int P_BC [N] = '{1, 1, 0};
   localparam int P_ND [N] = '{8, 3, 1};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [31:0] data [N];
   logic [7:0]  mask [N];
   logic [2:0]  sel_o [N];
   logic [3:0]  nib_o [N];
   logic        blank_o [N];
   logic        fd_o [N];

   int checks = 0;
   int failures = 0;

   // reference model: position in slot, current digit, frame snapshot as digit array
   int   m_pos [N];
   int   m_sel [N];
   int   m_guard [N];
   logic m_en [N];
   logic m_fd [N];
   logic [3:0] m_dig [N][8];
   logic m_msk [N][8];

   always #5 clk = ~clk;

   display_scan_ctrl #(.CLK_DIV(P_CD[0]), .BLANK_CYC(P_BC[0]), .NUM_DIGITS(P_ND[0])) u_dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .digit_data(data[0]), .blank_mask(mask[0]),
      .sel(sel_o[0]), .nibble(nib_o[0]), .blank(blank_o[0]), .frame_done(fd_o[0]));
   display_scan_ctrl #(.CLK_DIV(P_CD[1]), .BLANK_CYC(P_BC[1]), .NUM_DIGITS(P_ND[1])) u_dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .digit_data(data[1]), .blank_mask(mask[1]),
      .sel(sel_o[1]), .nibble(nib_o[1]), .blank(blank_o[1]), .frame_done(fd_o[1]));
   display_scan_ctrl #(.CLK_DIV(P_CD[2]), .BLANK_CYC(P_BC[2]), .NUM_DIGITS(P_ND[2])) u_dut2 (
      .clk(clk), .rst_n(rst_n), .en(en), .digit_data(data[2]), .blank_mask(mask[2]),
      .sel(sel_o[2]), .nibble(nib_o[2]), .blank(blank_o[2]), .frame_done(fd_o[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic lz_exp(input int i);
`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
      if (m_sel[i] == 0) return 1'b0;
      for (int k = m_sel[i]; k < P_ND[i]; k++)
         if (m_dig[i][k] != 4'h0) return 1'b0;
      return 1'b1;
`else
      return (i < 0);
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_pos[i] = 0; m_sel[i] = 0; m_guard[i] = 0; m_en[i] = 1'b0; m_fd[i] = 1'b0;
         for (int k = 0; k < 8; k++) begin
            m_dig[i][k] = 4'h0;
            m_msk[i][k] = 1'b0;
         end
      end
   endtask

   task automatic model_load(input int i);
      logic [31:0] d;
      d = data[i];
      for (int k = 0; k < 8; k++) begin
         m_dig[i][k] = d[4*k +: 4];
         m_msk[i][k] = mask[i][k];
      end
   endtask

   task automatic model_edge(input int i);
      m_fd[i] = 1'b0;
      if (!en) begin
         m_pos[i] = 0;
         m_guard[i] = 0;
         model_load(i);
      end else if (m_pos[i] == P_CD[i] - 1) begin
         m_pos[i] = 0;
         m_sel[i] = (m_sel[i] + 1) % P_ND[i];
         m_guard[i] = P_BC[i];
         if (m_sel[i] == 0) begin
            m_fd[i] = 1'b1;
            model_load(i);
         end
      end else begin
         m_pos[i]++;
         if (m_guard[i] > 0) m_guard[i]--;
      end
      m_en[i] = en;
   endtask

   task automatic compare_all();
      logic eb;
      for (int i = 0; i < N; i++) begin
         eb = !m_en[i] || (m_guard[i] > 0) || m_msk[i][m_sel[i]] || lz_exp(i);
         check($sformatf("sel%0d", i),    32'(sel_o[i]),   32'(m_sel[i]));
         check($sformatf("nibble%0d", i), 32'(nib_o[i]),   32'(m_dig[i][m_sel[i]]));
         check($sformatf("blank%0d", i),  32'(blank_o[i]), 32'(eb));
         check($sformatf("fdone%0d", i),  32'(fd_o[i]),    32'(m_fd[i]));
      end
   endtask

   int fd_count = 0;

   task automatic cycle();
      @(posedge clk);
      for (int i = 0; i < N; i++) model_edge(i);
      @(negedge clk);
      compare_all();
      if (fd_o[0]) fd_count++;
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) cycle();
   endtask

   task automatic wait_dut0(input int want_sel, input int want_pos, input string tag);
      int t;
      t = 0;
      while (t < 300 && !(m_sel[0] == want_sel && (want_pos < 0 || m_pos[0] == want_pos))) begin
         cycle();
         t++;
      end
      check(tag, 32'(m_sel[0] == want_sel), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         data[i] = 32'h0;
         mask[i] = 8'h0;
      end
      data[0] = 32'h76543210;
      data[1] = 32'h00000A21;
      mask[1] = 8'b0000_0010;
      data[2] = 32'h0000000C;
      model_reset();
      repeat (3) @(negedge clk);
      compare_all();
      rst_n = 1'b1;

      // basic scan, first enabled slot starts on the edge after en rises
      cycle();
      en = 1'b1;
      fd_count = 0;
      run(64);
      check("fd_count_64", 32'(fd_count), 32'd2);

      // snapshot integrity: mid-frame data change only visible from next frame
      wait_dut0(3, -1, "wait_sel3");
      data[0] = 32'hFFFFFFFF;
      run(40);

      // enable gating at prescaler=2, sel=5
      wait_dut0(5, 2, "wait_sel5_p2");
      en = 1'b0;
      run(20);
      check("held_sel5", 32'(sel_o[0]), 32'd5);
      en = 1'b1;
      run(12);

      // async reset mid-slot, checked before any clock edge
      wait_dut0(6, -1, "wait_sel6");
      #1 rst_n = 1'b0;
      #1 model_reset();
      compare_all();
      #1 rst_n = 1'b1;
      run(40);

      // leading-zero pattern
      data[0] = 32'h00000120;
      mask[0] = 8'h00;
      run(80);

      // randomized traffic
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 15) == 0) en = ~en;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) begin
               data[i] = $urandom >> (4 * $urandom_range(0, 7));
               mask[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            end
         end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
